// File: rtl/write_dac_pkg.sv
// Shared definitions for the write_dac SPI DAC transmitter: frame layout,
// JPorts pin map, FSM state encoding and the frame builder.
package write_dac_pkg;

    localparam int FRAME_BITS  = 16;
    localparam int VALUE_BITS  = 8;
    localparam int PD_BITS     = 2;
    localparam int PAD_HI_BITS = 2;
    localparam int PAD_LO_BITS = 4;
    localparam int DIV_W       = 8;
    localparam int BIT_CNT_W   = 5;
    localparam int PORT_W      = 8;

    localparam int SYNC_IDX    = 0;
    localparam int DIN_IDX     = 1;
    localparam int SCLK_IDX    = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2
    } state_t;

    // Frame sent MSB first: two pad bits, power-down mode, then the sample
    // left-aligned into the DAC's 12-bit data field.
    function automatic logic [FRAME_BITS-1:0] build_frame(
        input logic [PD_BITS-1:0]    pd,
        input logic [VALUE_BITS-1:0] value
    );
        return {{PAD_HI_BITS{1'b0}}, pd, value, {PAD_LO_BITS{1'b0}}};
    endfunction

endpackage

// File: rtl/write_dac_sclk_gen.sv
// SCLK generator for write_dac: a half-period counter toggles the SCLK
// register every CLK_DIV cycles while running, and flags the cycle before
// each falling and rising transition so the FSM acts on the same edge.
module dac_sclk_gen
    import write_dac_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic [DIV_W-1:0] i_clk_div,
    output logic             o_sclk,
    output logic             o_fall_tick,
    output logic             o_rise_tick
);

    logic [DIV_W-1:0] r_cnt;
    logic             r_sclk;
    logic             w_terminal;

    assign w_terminal  = i_run && (r_cnt == (i_clk_div - 8'd1));
    assign o_fall_tick = w_terminal && r_sclk;
    assign o_rise_tick = w_terminal && !r_sclk;
    assign o_sclk      = r_sclk;

    // Half-period counter and SCLK register; idle level is SCLK high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b1;
        end else if (!i_run) begin
            r_cnt  <= 8'd0;
            r_sclk <= 1'b1;
        end else if (w_terminal) begin
            r_cnt  <= 8'd0;
            r_sclk <= ~r_sclk;
        end else begin
            r_cnt  <= r_cnt + 8'd1;
            r_sclk <= r_sclk;
        end
    end

endmodule

// File: rtl/write_dac.sv
// write_dac: shifts {2'b00, PD_MODE, Value, 4'b0000} MSB first into a
// DAC121S101-class serial DAC over a Pmod JA-style port.
// JPorts: [0] SYNC_n, [1] DIN, [2] 0, [3] SCLK, [7:4] 0. All pins registered.
// Optional macro WRITE_DAC_AUTO_UPDATE_EN: also start a frame whenever Value
// differs from the last value sent, so no start pulses are needed.
module write_dac
    import write_dac_pkg::*;
#(
    parameter int           CLK_DIV = 4,
    parameter logic [1:0]   PD_MODE = 2'b00,
    parameter int           GAP_CYC = 8
) (
    input  logic                  sys_clk,
    input  logic                  reset,
    input  logic [VALUE_BITS-1:0] Value,
    input  logic                  start,
    output logic                  busy,
    output logic                  done,
    output logic [PORT_W-1:0]     JPorts
);

    localparam int                   GAP_W     = $clog2(GAP_CYC + 1);
    localparam logic [GAP_W-1:0]     GAP_LAST  = GAP_W'(GAP_CYC - 1);
    localparam logic [DIV_W-1:0]     DIV_VAL   = DIV_W'(CLK_DIV);
    localparam logic [BIT_CNT_W-1:0] BITS_LAST = BIT_CNT_W'(FRAME_BITS);

    state_t                  r_state;
    logic [FRAME_BITS-1:0]   r_shift;
    logic [BIT_CNT_W-1:0]    r_bit_cnt;
    logic [GAP_W-1:0]        r_gap_cnt;
    logic                    r_sync;
    logic                    r_din;
    logic                    r_busy;
    logic                    r_done;

    state_t                  w_state_nxt;
    logic [FRAME_BITS-1:0]   w_shift_nxt;
    logic [BIT_CNT_W-1:0]    w_bit_cnt_nxt;
    logic [GAP_W-1:0]        w_gap_cnt_nxt;
    logic                    w_sync_nxt;
    logic                    w_din_nxt;
    logic                    w_busy_nxt;
    logic                    w_done_nxt;

    logic                    w_run;
    logic                    w_sclk;
    logic                    w_fall_tick;
    logic                    w_rise_tick;
    logic                    w_accept;
    logic [FRAME_BITS-1:0]   w_frame;
    logic [PORT_W-1:0]       w_jports;

    assign w_run   = (r_state == SHIFT);
    assign w_frame = build_frame(PD_MODE, Value);

`ifdef WRITE_DAC_AUTO_UPDATE_EN
    logic [VALUE_BITS-1:0] r_last_sent;

    assign w_accept = (start || (Value != r_last_sent)) && (r_state == IDLE);

    // Remember the sample of the most recently accepted frame.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_last_sent <= 8'd0;
        end else if (w_accept) begin
            r_last_sent <= Value;
        end else begin
            r_last_sent <= r_last_sent;
        end
    end
`else
    assign w_accept = start && (r_state == IDLE);
`endif

    dac_sclk_gen u_sclk_gen (
        .i_clk       (sys_clk),
        .i_rst       (reset),
        .i_run       (w_run),
        .i_clk_div   (DIV_VAL),
        .o_sclk      (w_sclk),
        .o_fall_tick (w_fall_tick),
        .o_rise_tick (w_rise_tick)
    );

    // Next-state and next-output logic for the IDLE/SHIFT/GAP sequencer.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_bit_cnt_nxt = r_bit_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_sync_nxt    = r_sync;
        w_din_nxt     = r_din;
        w_busy_nxt    = r_busy;
        w_done_nxt    = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_state_nxt   = SHIFT;
                    w_shift_nxt   = w_frame;
                    w_bit_cnt_nxt = 5'd0;
                    w_sync_nxt    = 1'b0;
                    w_din_nxt     = w_frame[FRAME_BITS-1];
                    w_busy_nxt    = 1'b1;
                end else begin
                    w_sync_nxt    = 1'b1;
                    w_din_nxt     = 1'b0;
                    w_busy_nxt    = 1'b0;
                end
            end

            SHIFT: begin
                if (w_fall_tick) begin
                    // DAC samples DIN on this SCLK fall.
                    w_bit_cnt_nxt = r_bit_cnt + 5'd1;
                end else if (w_rise_tick) begin
                    if (r_bit_cnt == BITS_LAST) begin
                        // Rise after the last sampled bit closes the frame.
                        w_state_nxt   = GAP;
                        w_sync_nxt    = 1'b1;
                        w_din_nxt     = 1'b0;
                        w_gap_cnt_nxt = '0;
                    end else begin
                        w_shift_nxt   = {r_shift[FRAME_BITS-2:0], 1'b0};
                        w_din_nxt     = r_shift[FRAME_BITS-2];
                    end
                end else begin
                    w_bit_cnt_nxt = r_bit_cnt;
                end
            end

            GAP: begin
                if (r_gap_cnt == GAP_LAST) begin
                    w_state_nxt   = IDLE;
                    w_gap_cnt_nxt = '0;
                    w_busy_nxt    = 1'b0;
                    w_done_nxt    = 1'b1;
                end else begin
                    w_gap_cnt_nxt = r_gap_cnt + 1'b1;
                end
            end

            default: begin
                w_state_nxt   = IDLE;
                w_shift_nxt   = 16'h0000;
                w_bit_cnt_nxt = 5'd0;
                w_gap_cnt_nxt = '0;
                w_sync_nxt    = 1'b1;
                w_din_nxt     = 1'b0;
                w_busy_nxt    = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers; reset drops any frame in flight.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state   <= IDLE;
            r_shift   <= 16'h0000;
            r_bit_cnt <= 5'd0;
            r_gap_cnt <= '0;
            r_sync    <= 1'b1;
            r_din     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_sync    <= w_sync_nxt;
            r_din     <= w_din_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
        end
    end

    // Pin map onto the JA-style port; every driven bit comes from a register.
    always_comb begin
        w_jports           = 8'h00;
        w_jports[SYNC_IDX] = r_sync;
        w_jports[DIN_IDX]  = r_din;
        w_jports[SCLK_IDX] = w_sclk;
    end

    assign JPorts = w_jports;
    assign busy   = r_busy;
    assign done   = r_done;

endmodule

// File: tb/tb_write_dac.sv
// Scoreboard bench for write_dac: stimulus pushes expected frames, a monitor
// deserialises DIN on SCLK falls and checks frame words and timing.
module tb_write_dac;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] val_a, val_b;
    logic       start_a, start_b;
    logic       busy_a, busy_b, done_a, done_b;
    logic [7:0] jp_a, jp_b;

    always #5 clk = ~clk;

    write_dac u_a (
        .sys_clk (clk), .reset (rst), .Value (val_a), .start (start_a),
        .busy (busy_a), .done (done_a), .JPorts (jp_a)
    );

    write_dac #(.CLK_DIV(1), .PD_MODE(2'b11), .GAP_CYC(8)) u_b (
        .sys_clk (clk), .reset (rst), .Value (val_b), .start (start_b),
        .busy (busy_b), .done (done_b), .JPorts (jp_b)
    );

    typedef struct {
        int          inst;
        logic [15:0] word;
        int          sync_len;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_done [2];
    int   done_cnt [2];
    int   div_of   [2];

    task automatic check(input bit ok, input string name, input int act, input int req);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push(input int inst, input logic [15:0] word, input int len);
        exp_t e;
        e.inst = inst; e.word = word; e.sync_len = len;
        sb.push_back(e);
        exp_done[inst]++;
    endtask

    task automatic pulse_start(input int inst, input logic [7:0] v);
        if (inst == 0) begin val_a = v; start_a = 1'b1; end
        else           begin val_b = v; start_b = 1'b1; end
        @(posedge clk); #1;
        start_a = 1'b0; start_b = 1'b0;
    endtask

    task automatic wait_idle(input int inst);
        int quiet = 0;
        int n = 0;
        while (quiet < 20 && n < 3000) begin
            @(posedge clk); #1;
            n++;
            if ((inst == 0 ? busy_a : busy_b) == 1'b0) quiet++;
            else quiet = 0;
        end
        if (quiet < 20) check(1'b0, "idle_timeout", n, 3000);
    endtask

    // Monitor: runs on the falling clock edge, away from the active edge.
    logic [7:0]  m_jp;
    logic        m_busy, m_done, m_sync, m_sclk, m_din, m_fall;
    logic        prev_sync [2];
    logic        prev_sclk [2];
    logic        prev_busy [2];
    logic [15:0] cap       [2];
    int          nbits [2], slow [2], shigh [2], blen [2];
    exp_t        e;

    initial begin
        div_of[0] = 4; div_of[1] = 1;
        exp_done[0] = 0; exp_done[1] = 0;
        done_cnt[0] = 0; done_cnt[1] = 0;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                m_jp   = (i == 0) ? jp_a   : jp_b;
                m_busy = (i == 0) ? busy_a : busy_b;
                m_done = (i == 0) ? done_a : done_b;
                if (rst) begin
                    prev_sync[i] = 1'b1; prev_sclk[i] = 1'b1; prev_busy[i] = 1'b0;
                    cap[i] = 16'h0000; nbits[i] = 0; slow[i] = 0;
                    shigh[i] = 100; blen[i] = 0;
                end else begin
                    m_sync = m_jp[0]; m_din = m_jp[1]; m_sclk = m_jp[3];
                    if (prev_sync[i] && !m_sync) begin
                        check(shigh[i] >= 9, "sync_high_gap", shigh[i], 9);
                        slow[i] = 0; nbits[i] = 0; cap[i] = 16'h0000;
                    end
                    if (!m_sync) begin
                        slow[i]++;
                        if (prev_sclk[i] && !m_sclk) begin
                            cap[i] = {cap[i][14:0], m_din};
                            nbits[i]++;
                        end
                    end else begin
                        shigh[i]++;
                    end
                    if (!prev_sync[i] && m_sync) begin
                        shigh[i] = 1;
                        if (sb.size() == 0) begin
                            check(1'b0, "unexpected_frame", cap[i], i);
                        end else begin
                            e = sb.pop_front();
                            check(e.inst == i, "frame_inst", i, e.inst);
                            check(cap[i] == e.word, "frame_word", cap[i], e.word);
                            check(nbits[i] == 16, "frame_bits", nbits[i], 16);
                            check(slow[i] == e.sync_len, "sync_low_len", slow[i], e.sync_len);
                        end
                    end
                    m_fall = prev_busy[i] && !m_busy;
                    if (m_busy) blen[i]++;
                    if (m_fall) begin
                        check(blen[i] == 32 * div_of[i] + 8, "busy_len", blen[i], 32 * div_of[i] + 8);
                        check(m_done == 1'b1, "done_at_busy_fall", m_done, 1);
                        blen[i] = 0;
                    end
                    if (m_done) begin
                        done_cnt[i]++;
                        if (!m_fall) check(1'b0, "done_stray", m_done, 0);
                    end
                    prev_sync[i] = m_sync;
                    prev_sclk[i] = m_sclk;
                    prev_busy[i] = m_busy;
                end
            end
        end
    end

    // Directed stimulus.
    initial begin
        bit quiet_ok;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; val_a = 8'h00; val_b = 8'h00;
        repeat (3) @(posedge clk); #1;
        check(jp_a == 8'h09, "reset_jports_a", jp_a, 8'h09);
        check(jp_b == 8'h09, "reset_jports_b", jp_b, 8'h09);
        check(busy_a == 1'b0 && done_a == 1'b0, "reset_busy_done", {busy_a, done_a}, 0);
        rst = 1'b0;
        repeat (5) @(posedge clk); #1;

        // Single frame at defaults.
        push(0, 16'h0A50, 128);
        pulse_start(0, 8'hA5);
        wait_idle(0);

        // Value changes mid-frame must not alter the word in flight.
        push(0, 16'h0000, 128);
`ifdef WRITE_DAC_AUTO_UPDATE_EN
        push(0, 16'h0800, 128);
`endif
        pulse_start(0, 8'h00);
        repeat (9) @(posedge clk); #1;
        val_a = 8'h80;
        wait_idle(0);

        // A start pulse while busy is ignored.
        push(0, 16'h05A0, 128);
        pulse_start(0, 8'h5A);
        repeat (50) @(posedge clk); #1;
        start_a = 1'b1;
        @(posedge clk); #1;
        start_a = 1'b0;
        wait_idle(0);

        // start held high: back-to-back frames at 137-cycle spacing.
        val_a = 8'h01;
        for (int k = 0; k < 4; k++) push(0, 16'h0010, 128);
        start_a = 1'b1;
        repeat (500) @(posedge clk); #1;
        start_a = 1'b0;
        wait_idle(0);

        // Reset 40 cycles into a frame aborts it immediately.
        pulse_start(0, 8'h01);
        repeat (39) @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check(jp_a[3:0] == 4'b1001, "midframe_reset_pins", jp_a[3:0], 4'b1001);
        check(busy_a == 1'b0, "midframe_reset_busy", busy_a, 0);
        val_a = 8'h00;
        repeat (3) @(posedge clk); #1;
        rst = 1'b0;
        quiet_ok = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(posedge clk); #1;
            if (!(jp_a[0] && jp_a[3] && !busy_a)) quiet_ok = 1'b0;
        end
        check(quiet_ok, "no_resume_after_reset", quiet_ok, 1);

        // Second configuration: PD_MODE=11, CLK_DIV=1.
        push(1, 16'h3FF0, 32);
        pulse_start(1, 8'hFF);
        wait_idle(1);

`ifdef WRITE_DAC_AUTO_UPDATE_EN
        // Value step alone launches exactly one frame.
        push(0, 16'h03C0, 128);
        val_a = 8'h3C;
        @(posedge clk); #1;
        check(jp_a[0] == 1'b0, "auto_sync_fall", jp_a[0], 0);
        wait_idle(0);
        repeat (200) @(posedge clk); #1;
`endif

        repeat (10) @(posedge clk); #1;
        check(sb.size() == 0, "scoreboard_empty", sb.size(), 0);
        check(done_cnt[0] == exp_done[0], "done_count_a", done_cnt[0], exp_done[0]);
        check(done_cnt[1] == exp_done[1], "done_count_b", done_cnt[1], exp_done[1]);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
